score_tracker: RTL and testbench
================================

Name: score_tracker

Overview:
- Sits directly downstream of the hammer and mole timer in the whack-a-mole datapath.
- Consumes per-mole events: new_mole, hit and mole timeout.
- Produces:
  - a difficulty-weighted score with a combo bonus,
  - a miss counter and a game-over request,
  - a high score,
  - a registered 4-digit BCD copy of the score for the HEX display driver.
- Replaces the ad-hoc +50 counting currently done inside the hammer.

Parameters:
- BASE_POINTS, 50, points for a hit at difficulty 0 with no combo.
- COMBO_STEP, 10, bonus points per combo level.
- COMBO_MAX, 5, combo saturation level.
- MAX_MISSES, 5, misses that end the game.
- SCORE_MAX, 9999, score saturation value (4 BCD digits).
- SCORE_W, 14, binary score width.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high; clears all state including high_score
- start  in  1  one-cycle pulse; clears score, combo, misses and game_over; keeps high_score
- game_active  in  1  high while the FSM is in play; while low, all event pulses are ignored
- difficulty  in  4  0 = easy, 1 = medium, 2 = hard; values >2 are treated as 2
- new_mole  in  1  one-cycle pulse: a new mole is displayed
- hit  in  1  one-cycle pulse from hammer: switch matched the mole position
- mole_timeout  in  1  one-cycle pulse: mole display time expired
- score  out  SCORE_W  binary score
- high_score  out  SCORE_W  best score since reset
- combo  out  3  current streak, 0..COMBO_MAX
- misses  out  3  miss count, 0..MAX_MISSES
- game_over  out  1  level; set when misses reaches MAX_MISSES, cleared by start or reset
- score_bcd  out  16  {thousands, hundreds, tens, ones}
- bcd_valid  out  1  high when score_bcd matches score

Behaviour:
- Reset values: score, high_score, combo, misses = 0; game_over = 0; score_bcd = 0; bcd_valid = 1; mole FSM in IDLE.
- Mole FSM states:
  - IDLE: no mole.
  - ARMED: mole up, not yet hit.
  - SCORED: mole hit; further hits ignored.
- Transitions (only when game_active = 1 and game_over = 0):
  - IDLE + new_mole -> ARMED.
  - ARMED + hit -> SCORED. Score += BASE_POINTS*(1+min(difficulty,2)) + COMBO_STEP*combo. combo = min(combo+1, COMBO_MAX).
  - ARMED + mole_timeout -> IDLE. misses += 1; combo = 0.
  - SCORED + mole_timeout -> IDLE. No score change.
  - SCORED + new_mole -> ARMED.
  - ARMED + new_mole, without a timeout in the same cycle: counted as a miss for the old mole, then -> ARMED.
  - hit in IDLE or SCORED: ignored. No penalty; combo unchanged.
- Simultaneous events:
  - hit and mole_timeout together in ARMED: the hit is scored, then -> IDLE, no miss.
  - mole_timeout and new_mole together: the timeout is processed, then -> ARMED.
  - start together with any event: start wins; FSM -> IDLE.
- Latency: score, combo and misses update on the clock edge after the event pulse (1 cycle).
- Arithmetic: score saturates at SCORE_MAX and never wraps. The addition is done at SCORE_W+1 bits, then clamped.
- Game over:
  - When misses reaches MAX_MISSES, game_over is set on the same edge.
  - Thereafter all events are ignored until start.
- High score update: high_score <= score when score > high_score. Checked on the cycle game_over rises and on the cycle game_active falls.
- BCD conversion:
  - Sequential double-dabble, SCORE_W shift cycles plus 1 load cycle.
  - A conversion starts on any score change; bcd_valid drops the cycle after the change.
  - score_bcd updates atomically when the conversion finishes; bcd_valid then rises.
  - If score changes mid-conversion, a pending flag is set; the conversion restarts after finishing, and score_bcd is not updated with stale data.
- Reset mid-conversion: converter aborted, score_bcd = 0, bcd_valid = 1.

Decomposition:
- Shared game package holds:
  - mole FSM state encoding (IDLE, ARMED, SCORED),
  - difficulty codes and DIFF_MAX = 2,
  - SCORE_MAX, SCORE_W.
- One sub-module: bin2bcd_seq
  - Ports: clk, reset, start, bin[SCORE_W-1:0], busy, done, bcd[15:0].
  - Owns the shift/add-3 loop.
- score_tracker owns the event FSM, arithmetic, the high-score compare and the pending/restart logic.

Test Plan:
- Difficulty 0: new_mole, then hit -> score 50 one cycle later, combo 1; after 15 cycles score_bcd = 0x0050, bcd_valid = 1.
- Difficulty 2, three consecutive hit moles -> score 150, 310, 480; combo 3.
- Hit, then a second hit on the same mole -> second hit ignored, score unchanged. Then timeout -> misses 0.
- Five unhit moles timing out -> misses 5, game_over = 1, high_score latched. Later hits are ignored until start; after start, score 0 and high_score kept.
- Preload near saturation (score 9980) at difficulty 2, combo 5 -> score 9999, no wrap; score_bcd = 0x9999.
- hit and mole_timeout in the same cycle, and a hit arriving during a BCD conversion -> hit scored, no miss; final score_bcd equals the final score with no stale intermediate value.

Source files
------------

// File: rtl/score_tracker_pkg.sv
// Shared whack-a-mole game definitions: mole FSM encoding, difficulty codes,
// score limits and the double-dabble digit adjust helper.
package score_tracker_pkg;

    localparam int SCORE_W   = 14;
    localparam int SCORE_MAX = 9999;
    localparam int DIFF_MAX  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        SCORED = 2'd2
    } mole_state_e;

    typedef enum logic [3:0] {
        DIFF_EASY   = 4'd0,
        DIFF_MEDIUM = 4'd1,
        DIFF_HARD   = 4'd2
    } diff_e;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
    function automatic logic [15:0] bcd_add3(input logic [15:0] digits);
        logic [15:0] res;
        res = digits;
        for (int i = 0; i < 4; i++) begin
            if (digits[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = digits[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one load cycle, then SCORE_W shift cycles; the
// result register only changes on the final shift, together with done.
module bin2bcd_seq
    import score_tracker_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [15:0]        bcd
);

    // start is sampled only while busy is low; done is a one-cycle pulse on the
    // cycle after the last shift, with bcd already holding the new value.
    logic [SCORE_W-1:0] sh_q, sh_d;
    logic [15:0]        acc_q, acc_d, acc_adj;
    logic [15:0]        bcd_q;
    logic [3:0]         cnt_q;
    logic               busy_q, done_q;

    always_comb begin
        acc_adj = bcd_add3(acc_q);
        acc_d   = {acc_adj[14:0], sh_q[SCORE_W-1]};
        sh_d    = {sh_q[SCORE_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q   <= '0;
            acc_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                sh_q   <= bin;
                acc_q  <= '0;
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sh_q  <= sh_d;
                acc_q <= acc_d;
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'(SCORE_W - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    bcd_q  <= acc_d;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/score_tracker.sv
// Whack-a-mole scoring: per-mole event FSM, weighted/combo score with
// saturation, miss counting, high score and a registered BCD copy of the score.
module score_tracker
    import score_tracker_pkg::*;
#(
    parameter int BASE_POINTS = 50,
    parameter int COMBO_STEP  = 10,
    parameter int COMBO_MAX   = 5,
    parameter int MAX_MISSES  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               game_active,
    input  logic [3:0]         difficulty,
    input  logic               new_mole,
    input  logic               hit,
    input  logic               mole_timeout,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [2:0]         combo,
    output logic [2:0]         misses,
    output logic               game_over,
    output logic [15:0]        score_bcd,
    output logic               bcd_valid,
    output mole_state_e        mole_state
);

    localparam int SW1 = SCORE_W + 1;

    mole_state_e        state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d, high_q, high_d, score_sat;
    logic [2:0]         combo_q, combo_d, misses_q, misses_d;
    logic               game_over_q, game_over_d, active_q;
    logic [15:0]        bcd_q, bcd_d;
    logic               valid_q, valid_d, pend_q, pend_d;
    logic [1:0]         diff_eff;
    logic [SW1-1:0]     hit_pts, sum_w;
    logic               do_hit, do_miss, hs_check, score_chg;
    logic               conv_start, conv_busy, conv_done;
    logic [15:0]        conv_bcd;

    always_comb begin
        diff_eff  = (difficulty > 4'(DIFF_MAX)) ? 2'(DIFF_MAX) : difficulty[1:0];
        hit_pts   = SW1'(BASE_POINTS) * (SW1'(diff_eff) + SW1'(1))
                  + SW1'(COMBO_STEP) * SW1'(combo_q);
        sum_w     = {1'b0, score_q} + hit_pts;
        score_sat = (sum_w > SW1'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum_w[SCORE_W-1:0];
    end

    // A hit always takes priority for the current mole; a timeout or a fresh
    // mole on an unhit mole costs a miss.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        combo_d     = combo_q;
        misses_d    = misses_q;
        game_over_d = game_over_q;
        do_hit      = 1'b0;
        do_miss     = 1'b0;
        if (start) begin
            state_d     = IDLE;
            score_d     = '0;
            combo_d     = '0;
            misses_d    = '0;
            game_over_d = 1'b0;
        end else if (game_active && !game_over_q) begin
            case (state_q)
                IDLE: begin
                    if (new_mole) state_d = ARMED;
                end
                ARMED: begin
                    if (hit) begin
                        do_hit  = 1'b1;
                        state_d = new_mole ? ARMED : (mole_timeout ? IDLE : SCORED);
                    end else if (mole_timeout) begin
                        do_miss = 1'b1;
                        state_d = new_mole ? ARMED : IDLE;
                    end else if (new_mole) begin
                        do_miss = 1'b1;
                        state_d = ARMED;
                    end
                end
                SCORED: begin
                    if (new_mole)          state_d = ARMED;
                    else if (mole_timeout) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (do_hit) begin
                score_d = score_sat;
                combo_d = (combo_q == 3'(COMBO_MAX)) ? combo_q : combo_q + 3'd1;
            end
            if (do_miss) begin
                misses_d = misses_q + 3'd1;
                combo_d  = '0;
                if (misses_d == 3'(MAX_MISSES)) game_over_d = 1'b1;
            end
        end
    end

    always_comb begin
        hs_check = (game_over_d && !game_over_q) || (active_q && !game_active);
        high_d   = (hs_check && (score_q > high_q)) ? score_q : high_q;
    end

    // A change seen while the converter is busy is remembered and converted
    // again, so a stale result is never published.
    always_comb begin
        score_chg  = (score_d != score_q);
        conv_start = !conv_busy && (score_chg || pend_q);
        pend_d     = conv_start ? 1'b0 : (score_chg ? 1'b1 : pend_q);
        bcd_d      = bcd_q;
        valid_d    = valid_q;
        if (score_chg) valid_d = 1'b0;
        if (conv_done && !pend_q && !score_chg) begin
            bcd_d   = conv_bcd;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            score_q     <= '0;
            high_q      <= '0;
            combo_q     <= '0;
            misses_q    <= '0;
            game_over_q <= 1'b0;
            active_q    <= 1'b0;
            bcd_q       <= '0;
            valid_q     <= 1'b1;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            high_q      <= high_d;
            combo_q     <= combo_d;
            misses_q    <= misses_d;
            game_over_q <= game_over_d;
            active_q    <= game_active;
            bcd_q       <= bcd_d;
            valid_q     <= valid_d;
            pend_q      <= pend_d;
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (score_d),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign score      = score_q;
    assign high_score = high_q;
    assign combo      = combo_q;
    assign misses     = misses_q;
    assign game_over  = game_over_q;
    assign score_bcd  = bcd_q;
    assign bcd_valid  = valid_q;
    assign mole_state = state_q;

endmodule

// File: tb/tb_score_tracker.sv
// Directed bench for score_tracker: hand-computed scores, misses, game over,
// saturation and BCD conversion behaviour.
module tb_score_tracker;
    import score_tracker_pkg::*;

    logic               clk = 1'b0;
    logic               reset, start, game_active;
    logic [3:0]         difficulty;
    logic               new_mole, hit, mole_timeout;
    logic [SCORE_W-1:0] score, high_score;
    logic [2:0]         combo, misses;
    logic               game_over, bcd_valid;
    logic [15:0]        score_bcd;
    mole_state_e        mole_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [SCORE_W-1:0] exp_q[$];

    score_tracker dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .game_active  (game_active),
        .difficulty   (difficulty),
        .new_mole     (new_mole),
        .hit          (hit),
        .mole_timeout (mole_timeout),
        .score        (score),
        .high_score   (high_score),
        .combo        (combo),
        .misses       (misses),
        .game_over    (game_over),
        .score_bcd    (score_bcd),
        .bcd_valid    (bcd_valid),
        .mole_state   (mole_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one cycle of event pulses; returns on the next negedge.
    task automatic pulse(input logic nm, input logic h, input logic to, input logic st);
        new_mole     = nm;
        hit          = h;
        mole_timeout = to;
        start        = st;
        @(negedge clk);
        new_mole     = 1'b0;
        hit          = 1'b0;
        mole_timeout = 1'b0;
        start        = 1'b0;
    endtask

    task automatic wait_bcd(input int budget);
        int n;
        n = 0;
        while (!bcd_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("bcd_wait_valid", bcd_valid, 1);
    endtask

    initial begin
        int   n;
        logic stale;
        reset = 1'b1; start = 1'b0; game_active = 1'b0; difficulty = 4'd0;
        new_mole = 1'b0; hit = 1'b0; mole_timeout = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_eq("rst_score", score, 0);
        check_eq("rst_high", high_score, 0);
        check_eq("rst_combo", combo, 0);
        check_eq("rst_misses", misses, 0);
        check_eq("rst_game_over", game_over, 0);
        check_eq("rst_bcd", score_bcd, 0);
        check_eq("rst_bcd_valid", bcd_valid, 1);
        check_eq("rst_state", mole_state, IDLE);

        // Difficulty 0, single hit, exact BCD latency
        game_active = 1'b1;
        pulse(1, 0, 0, 0);
        check_eq("d0_armed", mole_state, ARMED);
        pulse(0, 1, 0, 0);
        check_eq("d0_score", score, 50);
        check_eq("d0_combo", combo, 1);
        check_eq("d0_state", mole_state, SCORED);
        check_eq("d0_valid_drop", bcd_valid, 0);
        tick(14);
        check_eq("d0_valid_cyc14", bcd_valid, 0);
        tick(1);
        check_eq("d0_valid_cyc15", bcd_valid, 1);
        check_eq("d0_bcd", score_bcd, 16'h0050);

        // Difficulty 2, three hit moles in a row
        pulse(0, 0, 0, 1);
        check_eq("start_score", score, 0);
        check_eq("start_combo", combo, 0);
        difficulty = DIFF_HARD;
        exp_q.push_back(14'd150);
        exp_q.push_back(14'd310);
        exp_q.push_back(14'd480);
        for (int i = 0; i < 3; i++) begin
            pulse(1, 0, 0, 0);
            pulse(0, 1, 0, 0);
            check_eq("d2_score", score, exp_q.pop_front());
        end
        check_eq("d2_combo", combo, 3);

        // Second hit on the same mole, then its timeout
        pulse(0, 1, 0, 0);
        check_eq("rehit_score", score, 480);
        check_eq("rehit_combo", combo, 3);
        pulse(0, 0, 1, 0);
        check_eq("scored_to_misses", misses, 0);
        check_eq("scored_to_state", mole_state, IDLE);
        wait_bcd(40);
        check_eq("bcd_480", score_bcd, 16'h0480);

        // Hit with timeout together, then a hit during the conversion
        pulse(1, 0, 0, 0);
        pulse(0, 1, 1, 0);
        check_eq("hit_to_score", score, 660);
        check_eq("hit_to_combo", combo, 4);
        check_eq("hit_to_misses", misses, 0);
        check_eq("hit_to_state", mole_state, IDLE);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        check_eq("midconv_score", score, 850);
        check_eq("midconv_combo", combo, 5);
        stale = 1'b0;
        n = 0;
        while (!bcd_valid && n < 60) begin
            if (score_bcd == 16'h0660) stale = 1'b1;
            @(negedge clk);
            n++;
        end
        if (score_bcd == 16'h0660) stale = 1'b1;
        check_eq("midconv_valid", bcd_valid, 1);
        check_eq("midconv_no_stale", stale, 0);
        check_eq("midconv_bcd", score_bcd, 16'h0850);

        // Misses up to game over
        pulse(1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        check_eq("nm_armed_misses", misses, 1);
        check_eq("nm_armed_combo", combo, 0);
        check_eq("nm_armed_state", mole_state, ARMED);
        pulse(0, 0, 1, 0);
        check_eq("to_misses2", misses, 2);
        for (int i = 0; i < 2; i++) begin
            pulse(1, 0, 0, 0);
            pulse(0, 0, 1, 0);
        end
        check_eq("to_misses4", misses, 4);
        check_eq("go_not_yet", game_over, 0);
        pulse(1, 0, 0, 0);
        pulse(0, 0, 1, 0);
        check_eq("go_misses5", misses, 5);
        check_eq("go_set", game_over, 1);
        check_eq("go_high", high_score, 850);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        check_eq("go_ignore_score", score, 850);
        check_eq("go_ignore_state", mole_state, IDLE);
        pulse(0, 0, 0, 1);
        check_eq("restart_score", score, 0);
        check_eq("restart_misses", misses, 0);
        check_eq("restart_go", game_over, 0);
        check_eq("restart_high", high_score, 850);

        // Events ignored while inactive
        game_active = 1'b0;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        check_eq("inactive_state", mole_state, IDLE);
        check_eq("inactive_score", score, 0);
        check_eq("inactive_high", high_score, 850);
        game_active = 1'b1;

        // Saturation, difficulty code above 2 treated as hard
        difficulty = 4'd9;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        check_eq("sat_first", score, 150);
        for (int i = 1; i < 50; i++) begin
            pulse(1, 0, 0, 0);
            pulse(0, 1, 0, 0);
        end
        check_eq("sat_9850", score, 9850);
        check_eq("sat_combo", combo, 5);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        check_eq("sat_clamp", score, 9999);
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        check_eq("sat_hold", score, 9999);
        wait_bcd(40);
        check_eq("sat_bcd", score_bcd, 16'h9999);
        game_active = 1'b0;
        tick(1);
        check_eq("active_fall_high", high_score, 9999);
        game_active = 1'b1;

        // Reset during a conversion
        pulse(0, 0, 0, 1);
        tick(3);
        check_eq("pre_rst_valid", bcd_valid, 0);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check_eq("midrst_bcd", score_bcd, 0);
        check_eq("midrst_valid", bcd_valid, 1);
        check_eq("midrst_high", high_score, 0);
        tick(20);
        check_eq("post_rst_valid", bcd_valid, 1);
        check_eq("post_rst_bcd", score_bcd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
